l2_grad: RTL and testbench
==========================

# l2_grad

Backward-pass counterpart of the L2 loss unit: for the first `num` elements of a prediction/target vector it computes the L2 gradient `grad[k] = 2*(yHat[k] - y[k])` in signed fixed point with saturation. It streams the results one element per accepted handshake and also keeps them in a parallel gradient array. It sits between the loss stage and the weight-update logic of the training datapath, started by the same `en`-style strobe the loss stage uses.

## Interface
- `IL`, 8, integer bits of the signed fixed-point format
- `FL`, 12, fraction bits; data width N = IL+FL
- `size`, 16, vector length (maximum element count)
- `width`, $clog2(size), width of `num` and `grad_idx`

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high; overrides every other input
- `en`  in  1  start strobe; sampled only in IDLE
- `yHat`  in  signed N x size  predictions
- `y`  in  signed N x size  targets
- `num`  in  width  number of elements to process, sampled with `en`
- `grad_ready`  in  1  downstream accepts `grad_out` this cycle
- `grad_valid`  out  1  `grad_out`/`grad_idx` hold a valid element
- `grad_out`  out  signed N  saturated gradient of element `grad_idx`
- `grad_idx`  out  width  index of the element on `grad_out`
- `grad`  out  signed N x size  gradient array
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `en`=1, `num`!=0:
  - Snapshot `yHat`, `y` and `num` into internal registers. Inputs are don't-care after this edge.
  - Clear all `grad` entries to 0.
  - Set idx=0, go to RUN.
- IDLE, `en`=1, `num`=0: go to DONE without visiting RUN. `grad` is not cleared.
- RUN:
  - `grad_valid`=1 and `busy`=1.
  - `grad_out` = gradient of snapshot element idx; `grad_idx` = idx.
  - When `grad_valid` and `grad_ready` are both 1 (accept):
    - Write `grad[idx] = grad_out`.
    - If idx == num_snap-1, go to DONE; otherwise idx++.
  - When `grad_ready`=0: `grad_out` and `grad_idx` hold stable.
- DONE: `done`=1 for exactly one cycle, `grad_valid`=0, then return to IDLE.
- `en` in RUN or DONE is ignored; there is no queueing.
- Arithmetic:
  - diff = yHat - y, sign-extended to N+1 bits.
  - g = diff <<< 1, N+2 bits.
  - Saturate to [-2^(N-1), 2^(N-1)-1], i.e. [-524288, 524287] at defaults.
  - No rounding is needed: the result is exact unless it saturates.
- Reset (any state, including mid-RUN):
  - Next state IDLE.
  - `grad_valid`, `busy`, `done`, `grad_out`, `grad_idx` = 0.
  - All `grad` entries = 0; snapshot registers = 0.
  - A partially streamed vector is abandoned; no `done` pulse.

## Timing
- Edge E: `en`=1 is sampled in IDLE.
- E+1: element 0 is on `grad_out` with `grad_valid`=1. All outputs are registered; no combinational input-to-output path.
- With `grad_ready` held at 1: one element per cycle; element k is accepted at edge E+1+k.
- The final accept moves to DONE; `done`=1 in the following cycle.
- Latency, `num`=n with no backpressure: `done` is high in cycle E+n+1.
- Latency, `num`=0: `done` is high in cycle E+1.
- After DONE, the earliest new start is `en` sampled in the cycle after `done`.
- `grad[k]` updates at the same edge that accepts element k.
- `reset` and `en` asserted together: `reset` wins and the block stays IDLE.

## Test plan
- Basic, `num`=2, `grad_ready`=1:
  - Stimulus: yHat[0]=4096 (1.0), y[0]=1024; yHat[1]=1024, y[1]=4096.
  - Required: `grad_out`=6144 then -6144 on consecutive cycles, `grad_idx` 0 then 1, `done` in cycle E+3, `grad[0..1]`={6144,-6144}, `grad[2..15]`=0.
- Saturation, `num`=2:
  - Stimulus: yHat[0]=524287, y[0]=-524288; yHat[1]=-524288, y[1]=524287.
  - Required: `grad_out`=524287 then -524288.
- Backpressure, `num`=3:
  - Stimulus: hold `grad_ready`=0 for 3 cycles while element 1 is presented.
  - Required: `grad_out`/`grad_idx`=1 stable with `grad_valid`=1 throughout; no skip or duplicate; `done` is delayed exactly 3 cycles versus the no-stall run.
- `num`=0:
  - Stimulus: `en`=1 in IDLE.
  - Required: `grad_valid` never asserts; `done`=1 in cycle E+1; `grad` unchanged from its prior contents.
- Snapshot and ignored start, `num`=4:
  - Stimulus: change `yHat`/`y`/`num` and pulse `en` during RUN.
  - Required: the output stream reflects the values captured at E only; exactly one `done`.
- Reset mid-RUN:
  - Stimulus: `num`=8, assert `reset` after 3 accepts.
  - Required: next cycle all outputs 0 and `grad` all 0, no `done`; a subsequent `en` restarts cleanly at `grad_idx`=0.

Source files
------------

// File: rtl/l2_grad.sv
// L2 loss backward pass: streams saturated grad[k] = 2*(yHat[k]-y[k]) for the first num
// elements over a valid/ready port and mirrors each accepted element into a gradient array.
module l2_grad #(
   parameter int IL    = 8,
   parameter int FL    = 12,
   parameter int size  = 16,
   parameter int width = $clog2(size)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [(IL+FL)*size-1:0]  yHat,
   input  logic [(IL+FL)*size-1:0]  y,
   input  logic [width-1:0]         num,
   input  logic                     grad_ready,
   output logic                     grad_valid,
   output logic [IL+FL-1:0]         grad_out,
   output logic [width-1:0]         grad_idx,
   output logic [(IL+FL)*size-1:0]  grad,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               dbg_state
);

   localparam int N = IL + FL;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [N*size-1:0]  yhat_s, y_s, grad_r;
   logic [width-1:0]   num_s, idx, idx_nxt;
   logic [N-1:0]       gout_r;
   logic               start, accept, last;

   // Handshake: an element transfers on any rising edge where grad_valid and grad_ready
   // are both high; while grad_ready is low, grad_out/grad_idx hold their values.

   // diff needs N+1 bits and doubling adds one more; saturate when the top three bits disagree.
   function automatic logic [N-1:0] sat_grad(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N+1:0] g;
      g = ({{2{a[N-1]}}, a} - {{2{b[N-1]}}, b}) << 1;
      if (g[N+1:N-1] == 3'b000 || g[N+1:N-1] == 3'b111)
         return g[N-1:0];
      else if (g[N+1])
         return {1'b1, {(N-1){1'b0}}};
      else
         return {1'b0, {(N-1){1'b1}}};
   endfunction

   always_comb begin
      start     = (state == IDLE) && en && (num != '0);
      accept    = (state == RUN) && grad_ready;
      last      = (idx == num_s - width'(1));
      idx_nxt   = idx + width'(1);
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = (num != '0) ? RUN : DONE;
         RUN:     if (accept && last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Element 0 comes straight from the inputs at start so it is on grad_out one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         yhat_s <= '0;
         y_s    <= '0;
         num_s  <= '0;
         grad_r <= '0;
         idx    <= '0;
         gout_r <= '0;
      end else if (start) begin
         yhat_s <= yHat;
         y_s    <= y;
         num_s  <= num;
         grad_r <= '0;
         idx    <= '0;
         gout_r <= sat_grad(yHat[N-1:0], y[N-1:0]);
      end else if (accept) begin
         grad_r[int'(idx)*N +: N] <= gout_r;
         if (!last) begin
            idx    <= idx_nxt;
            gout_r <= sat_grad(yhat_s[int'(idx_nxt)*N +: N], y_s[int'(idx_nxt)*N +: N]);
         end
      end
   end

   assign grad_valid = (state == RUN);
   assign busy       = (state == RUN);
   assign done       = (state == DONE);
   assign grad_out   = gout_r;
   assign grad_idx   = idx;
   assign grad       = grad_r;
   assign dbg_state  = state;

endmodule

// File: tb/tb_l2_grad.sv
// Bench for l2_grad: a queue-based gradient model checked every cycle, plus literal
// expectations for the directed scenarios (basic, saturation, stall, num=0, snapshot, reset).
module tb_l2_grad;

   localparam int N    = 20;
   localparam int SIZE = 16;
   localparam int W    = 4;
   localparam int GMAX = (1 << (N - 1)) - 1;
   localparam int GMIN = -(1 << (N - 1));

   logic              clk = 1'b0;
   logic              reset, en, grad_ready;
   logic [N*SIZE-1:0] yhat, y, grad;
   logic [W-1:0]      num, grad_idx;
   logic              grad_valid, busy, done;
   logic [N-1:0]      grad_out;
   logic [1:0]        dbg_state;

   int vec_cnt = 0;
   int err_cnt = 0;
   bit chk_on  = 1'b0;

   // model state
   bit           m_run  = 1'b0;
   bit           m_done = 1'b0;
   int           m_idx  = 0;
   logic [N-1:0] m_grad[SIZE];
   logic [N-1:0] exp_q[$];

   l2_grad dut (
      .clk(clk), .reset(reset), .en(en), .yHat(yhat), .y(y), .num(num),
      .grad_ready(grad_ready), .grad_valid(grad_valid), .grad_out(grad_out),
      .grad_idx(grad_idx), .grad(grad), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      @(posedge clk);
      #1 chk_on = 1'b1;
   end

   // ---------------- model ----------------
   function automatic int elem(input logic [N*SIZE-1:0] v, input int k);
      logic [N-1:0] e;
      e = v[k*N +: N];
      return int'($signed(e));
   endfunction

   function automatic logic [N-1:0] ref_grad(input int a, input int b);
      int g;
      g = 2 * (a - b);
      if (g > GMAX) g = GMAX;
      if (g < GMIN) g = GMIN;
      return g[N-1:0];
   endfunction

   initial begin
      foreach (m_grad[k]) m_grad[k] = '0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_run = 0; m_done = 0; m_idx = 0;
            exp_q.delete();
            foreach (m_grad[k]) m_grad[k] = '0;
         end else if (m_done) begin
            m_done = 0;
         end else if (m_run) begin
            if (grad_ready) begin
               m_grad[m_idx] = exp_q.pop_front();
               m_idx++;
               if (exp_q.size() == 0) begin
                  m_run  = 0;
                  m_done = 1;
               end
            end
         end else if (en) begin
            if (num == 0) m_done = 1;
            else begin
               for (int k = 0; k < int'(num); k++) exp_q.push_back(ref_grad(elem(yhat, k), elem(y, k)));
               foreach (m_grad[k]) m_grad[k] = '0;
               m_idx = 0;
               m_run = 1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vec_cnt++;
      if (act !== req) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      logic [N*SIZE-1:0] exp_grad;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            foreach (m_grad[k]) exp_grad[k*N +: N] = m_grad[k];
            chk("grad_valid", {31'd0, grad_valid}, {31'd0, m_run});
            chk("busy", {31'd0, busy}, {31'd0, m_run});
            chk("done", {31'd0, done}, {31'd0, m_done});
            if (m_run && exp_q.size() > 0) begin
               chk("grad_out", {12'd0, grad_out}, {12'd0, exp_q[0]});
               chk("grad_idx", {28'd0, grad_idx}, m_idx[31:0]);
            end
            vec_cnt++;
            if (grad !== exp_grad) begin
               err_cnt++;
               $display("FAIL grad_array: got %h expected %h at %0t", grad, exp_grad, $time);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   function automatic logic [N-1:0] rand_val();
      case ($urandom_range(0, 4))
         0:       return {1'b0, {(N-1){1'b1}}};
         1:       return {1'b1, {(N-1){1'b0}}};
         2:       return N'($urandom_range(0, 8191));
         default: return N'($urandom);
      endcase
   endfunction

   task automatic fill_random();
      for (int k = 0; k < SIZE; k++) begin
         yhat[k*N +: N] = rand_val();
         y[k*N +: N]    = rand_val();
      end
   endtask

   // returns at the negedge of cycle E+1
   task automatic start(input int n);
      @(negedge clk);
      en  = 1'b1;
      num = W'(n);
      @(negedge clk);
      en  = 1'b0;
   endtask

   // from cycle c0 onward, drive grad_ready until done; dc is the cycle (relative to E) of done
   task automatic drain(input int c0, input int stall_at, input int stall_len, input bit rnd,
                        output int dc);
      dc = -1;
      for (int c = c0; c <= 300; c++) begin
         if (done) begin
            dc = c;
            break;
         end
         if (rnd) grad_ready = ($urandom_range(0, 3) != 0);
         else     grad_ready = !(c >= stall_at && c < stall_at + stall_len);
         @(negedge clk);
      end
      grad_ready = 1'b1;
      if (dc < 0) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL done_timeout: no done within 300 cycles at %0t", $time);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int dc, dcnt, dcyc;
      reset = 1'b1; en = 1'b0; num = '0; grad_ready = 1'b1; yhat = '0; y = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, grad_valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_gout", {12'd0, grad_out}, 32'd0);
      reset = 1'b0;

      // basic
      yhat[0 +: N] = N'(4096); y[0 +: N] = N'(1024);
      yhat[N +: N] = N'(1024); y[N +: N] = N'(4096);
      start(2);
      chk("basic_g0", {12'd0, grad_out}, 32'd6144);
      chk("basic_i0", {28'd0, grad_idx}, 32'd0);
      @(negedge clk);
      chk("basic_g1", {12'd0, grad_out}, {12'd0, N'(-6144)});
      chk("basic_i1", {28'd0, grad_idx}, 32'd1);
      @(negedge clk);
      chk("basic_done_e3", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("basic_arr0", {12'd0, grad[0 +: N]}, 32'd6144);
      chk("basic_arr1", {12'd0, grad[N +: N]}, {12'd0, N'(-6144)});
      chk("basic_arr_rest", {31'd0, grad[N*SIZE-1:2*N] == '0}, 32'd1);

      // saturation
      yhat[0 +: N] = N'(GMAX); y[0 +: N] = N'(GMIN);
      yhat[N +: N] = N'(GMIN); y[N +: N] = N'(GMAX);
      start(2);
      chk("sat_pos", {12'd0, grad_out}, 32'd524287);
      @(negedge clk);
      chk("sat_neg", {12'd0, grad_out}, {12'd0, N'(-524288)});
      drain(2, 0, 0, 1'b0, dc);
      chk("sat_done_e3", dc[31:0], 32'd3);

      // backpressure versus no-stall
      fill_random();
      start(3);
      drain(1, 0, 0, 1'b0, dc);
      chk("nostall_done", dc[31:0], 32'd4);
      start(3);
      drain(1, 2, 3, 1'b0, dc);
      chk("stall_done", dc[31:0], 32'd7);

      // num = 0 keeps previous grad contents (model checks the array)
      start(0);
      chk("num0_done_e1", {31'd0, done}, 32'd1);
      chk("num0_valid", {31'd0, grad_valid}, 32'd0);

      // snapshot and ignored start during RUN
      @(negedge clk);
      fill_random();
      start(4);
      dcnt = 0; dcyc = -1;
      for (int c = 1; c <= 12; c++) begin
         if (done) begin dcnt++; dcyc = c; end
         en = (c == 1 || c == 3);
         if (c == 1) begin fill_random(); num = W'(7); end
         @(negedge clk);
      end
      en = 1'b0;
      chk("snap_done_cnt", dcnt[31:0], 32'd1);
      chk("snap_done_e5", dcyc[31:0], 32'd5);

      // reset mid-RUN after 3 accepts
      fill_random();
      start(8);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, grad_valid}, 32'd0);
      chk("mid_rst_gout", {12'd0, grad_out}, 32'd0);
      chk("mid_rst_idx", {28'd0, grad_idx}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_grad", {31'd0, grad == '0}, 32'd1);
      reset = 1'b0;
      fill_random();
      start(5);
      chk("restart_idx", {28'd0, grad_idx}, 32'd0);
      chk("restart_valid", {31'd0, grad_valid}, 32'd1);
      drain(1, 0, 0, 1'b1, dc);

      // randomized vectors with random backpressure
      for (int t = 0; t < 30; t++) begin
         fill_random();
         start($urandom_range(0, SIZE - 1));
         drain(1, 0, 0, 1'b1, dc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
